// File: rtl/led_ctrl_pkg.sv
// Shared constants and LED drive helper for the serial LED controller.
package led_ctrl_pkg;
  localparam int MODE_W      = 2;
  localparam int ADDR_W_DEF  = 5;
  localparam int SYNC_STAGES = 2;
  localparam int ARM_CYCLES  = 3;

  localparam logic [MODE_W-1:0] MODE_OFF     = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ON      = 2'b01;
  localparam logic [MODE_W-1:0] MODE_PATTERN = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 2'b11;

  localparam logic [ADDR_W_DEF-1:0] BCAST_ADDR = '1;

  function automatic logic led_drive(input logic [MODE_W-1:0] m, input logic pat,
                                     input logic blink);
    logic o;
    case (m)
      MODE_ON:      o = 1'b1;
      MODE_PATTERN: o = pat;
      MODE_BLINK:   o = blink;
      default:      o = 1'b0;
    endcase
    return o;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with a third flop for rising-edge detection.
// rise is masked by arm so pins already high at reset release stay quiet.
module sync_edge_det
  import led_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES:0] sh;

  always_ff @(posedge clk) begin
    if (rst) sh <= '0;
    else     sh <= {sh[SYNC_STAGES-1:0], d};
  end

  // level comes from the edge flop so level and rise share one timing reference
  assign level = sh[SYNC_STAGES];
  assign rise  = arm & sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES];
endmodule

// File: rtl/led_serial_ctrl.sv
// Serial-command LED controller: shifts {mode,addr} words in on SCLK, decodes on SLATCH.
// Optional daisy-chain output on SDO when LED_DAISY_CHAIN_EN is defined.
module led_serial_ctrl #(
  parameter int NUM_LEDS    = 16,
  parameter int ADDR_W      = 5,
  parameter int MODE_W      = led_ctrl_pkg::MODE_W,
  parameter int BLINK_DIV_W = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SCLK,
  input  logic                SDATA,
  input  logic                SLATCH,
  input  logic                PATTERN,
  output logic [NUM_LEDS-1:0] LED,
  output logic                CMD_OK,
  output logic                CMD_ERR,
  output logic                SDO
);
  import led_ctrl_pkg::*;

  localparam int WORD_W = MODE_W + ADDR_W;
  localparam int CNT_W  = $clog2(WORD_W + 2);

  logic [1:0]                      arm_cnt;
  logic                            arm;
  logic                            sclk_rise, slatch_rise, sdata_lvl, pat_lvl;
  logic                            sclk_lvl, slatch_lvl, sdata_rise, pat_rise;
  logic [WORD_W-1:0]               sr, sr_nxt;
  logic [CNT_W-1:0]                bit_cnt, cnt_nxt;
  logic [NUM_LEDS-1:0][MODE_W-1:0] mode;
  logic [BLINK_DIV_W-1:0]          blink_cnt;
  logic [NUM_LEDS-1:0]             led_nxt;
  logic [ADDR_W-1:0]               addr;
  logic [MODE_W-1:0]               md;
  logic                            bcast, cmd_valid;

  always_ff @(posedge CLK) begin
    if (RESET)                         arm_cnt <= '0;
    else if (arm_cnt != 2'(ARM_CYCLES)) arm_cnt <= arm_cnt + 2'd1;
  end
  assign arm = (arm_cnt == 2'(ARM_CYCLES));

  sync_edge_det u_sclk   (.clk(CLK), .rst(RESET), .arm(arm), .d(SCLK),
                          .level(sclk_lvl),   .rise(sclk_rise));
  sync_edge_det u_sdata  (.clk(CLK), .rst(RESET), .arm(arm), .d(SDATA),
                          .level(sdata_lvl),  .rise(sdata_rise));
  sync_edge_det u_slatch (.clk(CLK), .rst(RESET), .arm(arm), .d(SLATCH),
                          .level(slatch_lvl), .rise(slatch_rise));
  sync_edge_det u_pat    (.clk(CLK), .rst(RESET), .arm(arm), .d(PATTERN),
                          .level(pat_lvl),    .rise(pat_rise));

  assign addr      = sr[ADDR_W-1:0];
  assign md        = sr[WORD_W-1 -: MODE_W];
  assign bcast     = (addr == {ADDR_W{1'b1}});
  assign cmd_valid = (bit_cnt == CNT_W'(WORD_W)) && (bcast || (addr < ADDR_W'(NUM_LEDS)));

  // A shift coinciding with a latch starts the next word with that bit.
  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = bit_cnt;
    if (slatch_rise) begin
      sr_nxt  = sclk_rise ? {{(WORD_W-1){1'b0}}, sdata_lvl} : '0;
      cnt_nxt = sclk_rise ? CNT_W'(1) : '0;
    end else if (sclk_rise) begin
      sr_nxt = {sr[WORD_W-2:0], sdata_lvl};
      if (bit_cnt != CNT_W'(WORD_W + 1)) cnt_nxt = bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sr      <= '0;
      bit_cnt <= '0;
      mode    <= '0;
      CMD_OK  <= 1'b0;
      CMD_ERR <= 1'b0;
    end else begin
      sr      <= sr_nxt;
      bit_cnt <= cnt_nxt;
      CMD_OK  <= slatch_rise & cmd_valid;
      CMD_ERR <= slatch_rise & ~cmd_valid;
      if (slatch_rise && cmd_valid) begin
        for (int i = 0; i < NUM_LEDS; i++)
          if (bcast || addr == ADDR_W'(i)) mode[i] <= md;
      end
    end
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      led_nxt[i] = led_drive(mode[i], pat_lvl, blink_cnt[BLINK_DIV_W-1]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      blink_cnt <= '0;
      LED       <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      LED       <= led_nxt;
    end
  end

`ifdef LED_DAISY_CHAIN_EN
  always_ff @(posedge CLK) begin
    if (RESET) SDO <= 1'b0;
    else       SDO <= sr_nxt[WORD_W-1];
  end
`else
  assign SDO = 1'b0;
`endif

endmodule

// File: tb/tb_led_serial_ctrl.sv
// Directed bench for led_serial_ctrl: command table plus hand-written timing sequences.
module tb_led_serial_ctrl;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic        SCLK = 1'b0, SDATA = 1'b0, SLATCH = 1'b0, PATTERN = 1'b0;
  logic [15:0] LED;
  logic        CMD_OK, CMD_ERR, SDO;
  int          checks = 0, errors = 0, cyc = 0;

  led_serial_ctrl #(.NUM_LEDS(16), .ADDR_W(5), .MODE_W(2), .BLINK_DIV_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .SCLK(SCLK), .SDATA(SDATA), .SLATCH(SLATCH),
    .PATTERN(PATTERN), .LED(LED), .CMD_OK(CMD_OK), .CMD_ERR(CMD_ERR), .SDO(SDO));

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  w;
    int          n;
    logic        pat;
    int          ok;
    int          err;
    logic [15:0] led;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic shift1(input logic b);
    SDATA = b;
    repeat (3) tick();
    SCLK = 1'b1;
    repeat (4) tick();
    SCLK = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) shift1(w[i]);
  endtask

  task automatic latch(output int nok, output int nerr);
    SLATCH = 1'b1;
    nok = 0;
    nerr = 0;
    repeat (6) begin
      tick();
      nok  += int'(CMD_OK);
      nerr += int'(CMD_ERR);
    end
    SLATCH = 1'b0;
    repeat (3) tick();
  endtask

  task automatic cmd(input string name, input logic [7:0] w, input int n,
                     input int eok, input int eerr, input logic [15:0] eled);
    int nok, nerr;
    send_bits(w, n);
    latch(nok, nerr);
    check({name, "_ok"}, nok, eok);
    check({name, "_err"}, nerr, eerr);
    check({name, "_led"}, LED, eled);
  endtask

  initial begin
    int nok, nerr;
    logic [6:0] a;
    vecs[0]  = '{8'b0100000, 7, 1'b0, 1, 0, 16'h0009};
    vecs[1]  = '{8'b0000011, 7, 1'b0, 1, 0, 16'h0001};
    vecs[2]  = '{8'b010010,  6, 1'b0, 0, 1, 16'h0001};
    vecs[3]  = '{8'b01000010, 8, 1'b0, 0, 1, 16'h0001};
    vecs[4]  = '{8'b0110100, 7, 1'b0, 0, 1, 16'h0001};
    vecs[5]  = '{8'b0110000, 7, 1'b0, 0, 1, 16'h0001};
    vecs[6]  = '{8'b0101111, 7, 1'b0, 1, 0, 16'h8001};
    vecs[7]  = '{8'b0111111, 7, 1'b0, 1, 0, 16'hffff};
    vecs[8]  = '{8'b0000101, 7, 1'b0, 1, 0, 16'hffdf};
    vecs[9]  = '{8'b0011111, 7, 1'b0, 1, 0, 16'h0000};
    vecs[10] = '{8'b1011111, 7, 1'b1, 1, 0, 16'hffff};
    vecs[11] = '{8'b0000101, 7, 1'b1, 1, 0, 16'hffdf};
    vecs[12] = '{8'b0011111, 7, 1'b1, 1, 0, 16'h0000};

    // reset state
    repeat (3) tick();
    check("rst_led", LED, 16'h0);
    check("rst_ok", CMD_OK, 1'b0);
    check("rst_err", CMD_ERR, 1'b0);
    check("rst_sdo", SDO, 1'b0);
    RESET = 1'b0;
    repeat (5) tick();

    // latency: LED[3] ON appears 3 edges after SLATCH is first sampled
    send_bits(8'b0100011, 7);
    SLATCH = 1'b1;
    tick();
    tick();
    check("lat_ok_early", CMD_OK, 1'b0);
    tick();
    check("lat_ok_pulse", CMD_OK, 1'b1);
    check("lat_led_early", LED, 16'h0000);
    tick();
    check("lat_led", LED, 16'h0008);
    check("lat_ok_end", CMD_OK, 1'b0);
    check("lat_err", CMD_ERR, 1'b0);
    SLATCH = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 13; i++) begin
      PATTERN = vecs[i].pat;
      cmd($sformatf("vec%0d", i), vecs[i].w, vecs[i].n, vecs[i].ok, vecs[i].err, vecs[i].led);
    end
    PATTERN = 1'b0;

    // broadcast PATTERN, follow the pin with a 3-edge lag
    cmd("bpat", 8'b1011111, 7, 1, 0, 16'h0000);
    PATTERN = 1'b1;
    repeat (3) tick();
    check("pat_rise_early", LED, 16'h0000);
    tick();
    check("pat_rise", LED, 16'hffff);
    PATTERN = 1'b0;
    repeat (3) tick();
    check("pat_fall_early", LED, 16'hffff);
    tick();
    check("pat_fall", LED, 16'h0000);
    PATTERN = 1'b1;
    cmd("pat_off5", 8'b0000101, 7, 1, 0, 16'hffdf);
    PATTERN = 1'b0;
    cmd("boff", 8'b0011111, 7, 1, 0, 16'h0000);

    // blink on LED0: counter is free-running from reset, MSB of a 4-bit divider
    cmd("blink", 8'b1100000, 7, 1, 0, ((((cyc - 1) >> 3) & 1) != 0) ? 16'h0001 : 16'h0000);
    for (int i = 0; i < 32; i++) begin
      tick();
      check($sformatf("blink%0d", i), LED, ((((cyc - 1) >> 3) & 1) != 0) ? 16'h0001 : 16'h0000);
    end
    cmd("boff2", 8'b0011111, 7, 1, 0, 16'h0000);

    // SCLK and SLATCH rising together after a full word
    send_bits(8'b0100101, 7);
    SDATA = 1'b0;
    repeat (3) tick();
    SCLK = 1'b1;
    SLATCH = 1'b1;
    nok = 0;
    nerr = 0;
    repeat (6) begin
      tick();
      nok  += int'(CMD_OK);
      nerr += int'(CMD_ERR);
    end
    SCLK = 1'b0;
    SLATCH = 1'b0;
    repeat (3) tick();
    check("sim_ok", nok, 1);
    check("sim_err", nerr, 0);
    check("sim_led", LED, 16'h0020);
    cmd("sim_next", 8'b100110, 6, 1, 0, 16'h0060);

    // reset mid-word discards the partial word
    send_bits(8'b0100, 4);
    RESET = 1'b1;
    repeat (2) tick();
    check("mid_rst_led", LED, 16'h0000);
    check("mid_rst_ok", CMD_OK, 1'b0);
    RESET = 1'b0;
    repeat (5) tick();
    cmd("post_rst", 8'b0100001, 7, 1, 0, 16'h0002);

    // SCLK high across reset release must not count a bit
    SCLK = 1'b1;
    RESET = 1'b1;
    repeat (3) tick();
    check("hold_rst_led", LED, 16'h0000);
    check("hold_rst_err", CMD_ERR, 1'b0);
    check("hold_rst_sdo", SDO, 1'b0);
    RESET = 1'b0;
    repeat (6) tick();
    SCLK = 1'b0;
    repeat (3) tick();
    cmd("hold_sclk", 8'b0100010, 7, 1, 0, 16'h0004);

    // daisy-chain output: SDO tracks the shift-register MSB
    a = 7'b1011001;
    for (int j = 0; j < 14; j++) begin
      shift1(j < 7 ? a[6 - j] : 1'b0);
`ifdef LED_DAISY_CHAIN_EN
      if (j >= 6) check($sformatf("sdo%0d", j), SDO, a[12 - j]);
`else
      check($sformatf("sdo%0d", j), SDO, 1'b0);
`endif
    end
    latch(nok, nerr);
    check("daisy_err", nerr, 1);
    check("daisy_led", LED, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
